// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
//   owner_e   : which requester a read response belongs to
//   rsp_tag_t : one in-flight read tag {vld, own}
//   STARVE_W  : width of the IF starvation counter
package mem_arb_pkg;

  localparam int unsigned STARVE_W = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e own;
  } rsp_tag_t;

endpackage

// File: rtl/rsp_tag_pipe.sv
// Fixed-latency tag delay line matching the memory read latency.
// A tag entering at a grant cycle leaves exactly MEM_LAT cycles later,
// lining up with the memory's read data.
//   clk, rst_n : clock, async active-low reset (clears all tags)
//   tag_in     : tag for the access granted this cycle
//   tag_out    : tag whose read data is on mem_rdata this cycle
module rsp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t [MEM_LAT-1:0] stage_q;

  // Shift register; no stall, so it advances every cycle.
  if (MEM_LAT == 1) begin : g_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= tag_in;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else begin
        stage_q <= {stage_q[MEM_LAT-2:0], tag_in};
      end
    end
  end

  assign tag_out = stage_q[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch (IF)
// and the load/store port (D). D has fixed priority; IF wins one arbitration
// after STARVE_MAX consecutive denials. Read responses are routed back to
// their owner via a tag pipe matched to the memory latency.
//   clk, rst_n                        : clock, async active-low reset
//   if_req/if_addr -> if_gnt          : IF read request / same-cycle grant
//   if_rvalid/if_rdata                : IF read response
//   d_req/d_w/d_addr/d_wdata -> d_gnt : D request / same-cycle grant
//   d_rvalid/d_rdata                  : D read response (reads only)
//   mem_en/mem_w/mem_addr/mem_wdata   : memory command
//   mem_rdata                         : memory read data, MEM_LAT after read
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_w,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  logic                if_wins;
  rsp_tag_t            tag_in;
  rsp_tag_t            tag_out;

  // Grant and memory command mux. Grants are combinational so a request is
  // accepted in the cycle it is presented; reset forces everything idle.
  always_comb begin
    if_wins   = if_req && (!d_req || (starve_cnt == STARVE_LIM));
    if_gnt    = rst_n && if_wins;
    d_gnt     = rst_n && d_req && !if_wins;
    mem_en    = if_gnt || d_gnt;
    mem_w     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_w     = d_w;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Consecutive IF denials, saturating; any grant or idle IF clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Only granted reads carry a valid tag; writes complete at grant.
  always_comb begin
    tag_in.vld = mem_en && !mem_w;
    tag_in.own = d_gnt ? OWN_D : OWN_IF;
  end

  rsp_tag_pipe #(
    .MEM_LAT(MEM_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign if_rvalid = tag_out.vld && (tag_out.own == OWN_IF);
  assign d_rvalid  = tag_out.vld && (tag_out.own == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a transaction model
// (priority rule, denial count, and a queue of expected read responses).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_w;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_w;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_w      (d_w),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_w    (mem_w),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Synchronous memory with MEM_LAT read latency, driven by the DUT.
  logic [DATA_W-1:0] bmem [256];
  logic [DATA_W-1:0] rd_pipe [MEM_LAT];
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  always @(posedge clk) begin
    if (mem_en && !mem_w) rd_pipe[0] <= bmem[mem_addr[7:0]];
    for (int i = 1; i < int'(MEM_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && mem_w) bmem[mem_addr[7:0]] = mem_wdata;
  end

  // Reference model: expected grants, denial count, response queue.
  typedef struct {
    owner_e            own;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_rsp_t;

  exp_rsp_t          rq[$];
  logic [DATA_W-1:0] shadow [256];
  int                m_starve = 0;
  logic              m_if_win, e_if_gnt, e_d_gnt;

  always_comb begin
    m_if_win = if_req && (!d_req || (m_starve == int'(STARVE_MAX)));
    e_if_gnt = rst_n && m_if_win;
    e_d_gnt  = rst_n && d_req && !m_if_win;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_starve = 0;
      rq.delete();
    end else begin
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (e_if_gnt)
        rq.push_back('{own: OWN_IF, data: shadow[if_addr[7:0]], due: cyc + int'(MEM_LAT)});
      if (e_d_gnt) begin
        if (d_w) shadow[d_addr[7:0]] = d_wdata;
        else rq.push_back('{own: OWN_D, data: shadow[d_addr[7:0]], due: cyc + int'(MEM_LAT)});
      end
      if (if_req && !e_if_gnt) m_starve = (m_starve < int'(STARVE_MAX)) ? m_starve + 1 : m_starve;
      else m_starve = 0;
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  logic              x_ifv, x_dv;
  logic [DATA_W-1:0] x_data;
  logic [ADDR_W-1:0] x_addr;
  always @(negedge clk) begin
    x_ifv  = 1'b0;
    x_dv   = 1'b0;
    x_data = '0;
    if (rst_n && rq.size() > 0 && rq[0].due == cyc) begin
      x_data = rq[0].data;
      if (rq[0].own == OWN_IF) x_ifv = 1'b1;
      else x_dv = 1'b1;
    end
    x_addr = e_if_gnt ? if_addr : (e_d_gnt ? d_addr : '0);
    chk("if_gnt", 64'(if_gnt), 64'(e_if_gnt));
    chk("d_gnt", 64'(d_gnt), 64'(e_d_gnt));
    chk("mem_en", 64'(mem_en), 64'(e_if_gnt || e_d_gnt));
    chk("mem_w", 64'(mem_w), 64'(e_d_gnt && d_w));
    chk("mem_addr", 64'(mem_addr), 64'(x_addr));
    if (e_d_gnt && d_w) chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
    else if (!e_if_gnt && !e_d_gnt) chk("mem_wdata_idle", 64'(mem_wdata), 64'(0));
    chk("if_rvalid", 64'(if_rvalid), 64'(x_ifv));
    chk("d_rvalid", 64'(d_rvalid), 64'(x_dv));
    if (x_ifv) chk("if_rdata", 64'(if_rdata), 64'(x_data));
    if (x_dv) chk("d_rdata", 64'(d_rdata), 64'(x_data));
    chk("starve_cnt", 64'(dut.starve_cnt), rst_n ? 64'(m_starve) : 64'(0));
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic got_if, got_d;

  initial begin
    for (int i = 0; i < 256; i++) begin
      bmem[i]   = init_word(i);
      shadow[i] = init_word(i);
    end
    for (int i = 0; i < int'(MEM_LAT); i++) rd_pipe[i] = '0;

    // Reset with both requesting: everything idle.
    rst_n   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h10;
    d_req   = 1'b1;
    d_w     = 1'b0;
    d_addr  = 32'h30;
    d_wdata = '0;
    @(negedge clk);
    chk("rst_if_gnt", 64'(if_gnt), 64'(0));
    chk("rst_d_gnt", 64'(d_gnt), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_if_rvalid", 64'(if_rvalid), 64'(0));
    chk("rst_d_rvalid", 64'(d_rvalid), 64'(0));
    nxt();
    rst_n = 1'b1;

    // Release with both held: D x4, IF once, repeating.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("starve_d_gnt", 64'(d_gnt), 64'((k % 5) != 4));
      chk("starve_if_gnt", 64'(if_gnt), 64'((k % 5) == 4));
      nxt();
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (4) nxt();

    // IF alone reads 0x10.
    if_req  = 1'b1;
    if_addr = 32'h10;
    @(negedge clk);
    chk("if_only_gnt", 64'(if_gnt), 64'(1));
    chk("if_only_mem_en", 64'(mem_en), 64'(1));
    chk("if_only_mem_w", 64'(mem_w), 64'(0));
    chk("if_only_mem_addr", 64'(mem_addr), 64'(32'h10));
    nxt();
    if_req = 1'b0;
    @(negedge clk);
    chk("if_only_early", 64'(if_rvalid), 64'(0));
    nxt();
    @(negedge clk);
    chk("if_only_rvalid", 64'(if_rvalid), 64'(1));
    chk("if_only_rdata", 64'(if_rdata), 64'(32'hA500_0010));
    nxt();

    // Back-to-back: D read 0x40, IF read 0x50, D write 0x60.
    d_req  = 1'b1;
    d_w    = 1'b0;
    d_addr = 32'h40;
    @(negedge clk);
    chk("b2b_d_gnt", 64'(d_gnt), 64'(1));
    nxt();
    d_req   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h50;
    @(negedge clk);
    chk("b2b_if_gnt", 64'(if_gnt), 64'(1));
    chk("b2b_if_mem_w", 64'(mem_w), 64'(0));
    nxt();
    if_req  = 1'b0;
    d_req   = 1'b1;
    d_w     = 1'b1;
    d_addr  = 32'h60;
    d_wdata = 32'h1234;
    @(negedge clk);
    chk("b2b_wr_mem_w", 64'(mem_w), 64'(1));
    chk("b2b_d_rvalid", 64'(d_rvalid), 64'(1));
    chk("b2b_d_rdata", 64'(d_rdata), 64'(32'hA500_0040));
    nxt();
    d_req = 1'b0;
    d_w   = 1'b0;
    @(negedge clk);
    chk("b2b_if_rvalid", 64'(if_rvalid), 64'(1));
    chk("b2b_if_rdata", 64'(if_rdata), 64'(32'hA500_0050));
    chk("b2b_idle_mem_w", 64'(mem_w), 64'(0));
    nxt();
    @(negedge clk);
    chk("b2b_wr_no_rvalid", 64'(if_rvalid || d_rvalid), 64'(0));
    nxt();

    // Mid-flight reset drops the outstanding read.
    d_req  = 1'b1;
    d_addr = 32'h70;
    @(negedge clk);
    chk("mfr_d_gnt", 64'(d_gnt), 64'(1));
    nxt();
    rst_n = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk("mfr_in_rst", 64'(d_rvalid), 64'(0));
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mfr_dropped", 64'(d_rvalid), 64'(0));
    chk("mfr_starve", 64'(dut.starve_cnt), 64'(0));
    nxt();
    @(negedge clk);
    chk("mfr_dropped_late", 64'(d_rvalid), 64'(0));
    nxt();

    // Write then read same address on consecutive cycles.
    d_req   = 1'b1;
    d_w     = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'hDEAD;
    @(negedge clk);
    chk("raw_wr_gnt", 64'(d_gnt), 64'(1));
    chk("raw_wr_wdata", 64'(mem_wdata), 64'(32'hDEAD));
    nxt();
    d_w = 1'b0;
    @(negedge clk);
    chk("raw_rd_gnt", 64'(d_gnt), 64'(1));
    nxt();
    d_req = 1'b0;
    @(negedge clk);
    chk("raw_early", 64'(d_rvalid), 64'(0));
    nxt();
    @(negedge clk);
    chk("raw_rvalid", 64'(d_rvalid), 64'(1));
    chk("raw_rdata", 64'(d_rdata), 64'(32'hDEAD));
    nxt();

    // IF withdraws before grant: count clears.
    if_req  = 1'b1;
    if_addr = 32'h11;
    d_req   = 1'b1;
    d_addr  = 32'h12;
    repeat (2) nxt();
    if_req = 1'b0;
    @(negedge clk);
    chk("drop_cnt_before", 64'(dut.starve_cnt), 64'(2));
    nxt();
    @(negedge clk);
    chk("drop_cnt_cleared", 64'(dut.starve_cnt), 64'(0));
    nxt();
    d_req = 1'b0;
    repeat (4) nxt();

    // Randomized traffic honouring hold-until-grant.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      got_if = e_if_gnt;
      got_d  = e_d_gnt;
      nxt();
      rst_n = ($urandom_range(0, 299) != 0);
      if (!if_req || got_if) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 32'($urandom_range(0, 255));
      end
      if (!d_req || got_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_w     = ($urandom_range(0, 2) == 0);
        d_addr  = 32'($urandom_range(0, 255));
        d_wdata = $urandom;
      end
    end
    rst_n  = 1'b1;
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (5) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
